// File: rtl/mem_pkg.sv
// Shared encodings, FSM states and defaults for the data-memory
// load/store unit.
package mem_pkg;

    localparam int MEM_DEPTH = 64;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RESP
    } state_t;

    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] off
    );
        return (size == SZ_HALF && off[0])
            || (size == SZ_WORD && off != 2'b00);
    endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Byte-lane steering: merges store data into a word and extracts
// extended load data from a word.
module mem_lane_unit
    import mem_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] store_word,
    output logic [31:0] load_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = old_word[7:0];
        case (off)
            2'd1:    byte_sel = old_word[15:8];
            2'd2:    byte_sel = old_word[23:16];
            2'd3:    byte_sel = old_word[31:24];
            default: byte_sel = old_word[7:0];
        endcase
        half_sel = off[1] ? old_word[31:16] : old_word[15:0];
    end

    always_comb begin
        store_word = old_word;
        load_word  = old_word;
        case (size)
            SZ_BYTE: begin
                case (off)
                    2'd1:    store_word[15:8]  = wdata[7:0];
                    2'd2:    store_word[23:16] = wdata[7:0];
                    2'd3:    store_word[31:24] = wdata[7:0];
                    default: store_word[7:0]   = wdata[7:0];
                endcase
                load_word = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                if (off[1])
                    store_word[31:16] = wdata[15:0];
                else
                    store_word[15:0] = wdata[15:0];
                load_word = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            end
            SZ_WORD: begin
                store_word = wdata;
                load_word  = old_word;
            end
            default: begin
                store_word = old_word;
                load_word  = old_word;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator: request latch, RMW sequencing FSM and
// response generation towards a word-addressed memory.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DEPTH = MEM_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_data
);

    localparam logic [29:0] LIMIT = 30'(DEPTH);

    state_t      state_q;
    state_t      state_d;
    logic        wr_q;
    logic        err_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic        accept;
    logic        req_err;
    logic [31:0] store_word;
    logic [31:0] load_word;

    assign accept  = req_valid && (state_q == IDLE);
    assign req_err = misaligned(req_size, req_addr[1:0])
                  || req_size == 2'b11
                  || req_addr[31:2] >= LIMIT;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                wr_q    <= req_write;
                err_q   <= req_err;
                uns_q   <= req_unsigned;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state_q == RD)
                word_q <= mem_data;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_d = RESP;
                    else if (!req_write)
                        state_d = RD;
                    else if (req_size == SZ_WORD)
                        state_d = WR;
                    else
                        state_d = RD;
                end
            end
            RD:      state_d = wr_q ? WR : RESP;
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    mem_lane_unit u_lane (
        .off         (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .old_word    (word_q),
        .wdata       (wdata_q),
        .store_word  (store_word),
        .load_word   (load_word)
    );

    // Strobes decode straight from state so reset drops them at once.
    assign req_ready      = (state_q == IDLE);
    assign mem_read       = (state_q == RD);
    assign mem_write      = (state_q == WR);
    assign mem_write_data = mem_write ? store_word : '0;
    assign mem_address    = {2'b00, addr_q[31:2]};
    assign resp_valid     = (state_q == RESP);
    assign resp_err       = resp_valid && err_q;
    assign resp_rdata     = (resp_valid && !err_q && !wr_q) ? load_word : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a
// behavioural 64-word memory.
module tb_mem_access_unit;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_data;

    logic [31:0] mem [0:63];

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0]  o_rd, o_wr, o_rv;
    logic [31:0] o_rdata, o_wdata, o_addr;
    logic        o_err;

    always #5 clk = ~clk;

    mem_access_unit #(.DEPTH(64)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_data       (mem_data)
    );

    assign mem_data = mem[mem_address[5:0]];

    always @(posedge clk)
        if (mem_write)
            mem[mem_address[5:0]] <= mem_write_data;

    task automatic issue(input logic w, input logic [1:0] s,
                         input logic u, input logic [31:0] a,
                         input logic [31:0] d);
        @(negedge clk);
        req_write    = w;
        req_size     = s;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = d;
        req_valid    = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Records cycles 1..4 after the accept edge (bit 0 = cycle 1).
    task automatic observe();
        o_rd = '0; o_wr = '0; o_rv = '0;
        o_rdata = 32'hx; o_wdata = 32'hx; o_addr = 32'hx; o_err = 1'bx;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            o_rd[c] = mem_read;
            o_wr[c] = mem_write;
            o_rv[c] = resp_valid;
            if (mem_read || mem_write) o_addr = mem_address;
            if (mem_write) o_wdata = mem_write_data;
            if (resp_valid) begin
                o_rdata = resp_rdata;
                o_err   = resp_err;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hs: ready=%b rv=%b err=%b want 1 0 0",
                     req_ready, resp_valid, resp_err);
        end
        n_cmp++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_strobe: rd=%b wr=%b want 0 0", mem_read, mem_write);
        end
        n_cmp++;
        if (mem_address !== 32'h0 || mem_write_data !== 32'h0 || resp_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_data: addr=%h wd=%h rdata=%h want 0 0 0",
                     mem_address, mem_write_data, resp_rdata);
        end
        reset = 1'b1;
    endtask

    task automatic test_word_store_load();
        issue(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF);
        observe();
        n_cmp++;
        if ({o_rd, o_wr, o_rv} !== {4'b0000, 4'b0001, 4'b0010}) begin
            n_bad++;
            $display("FAIL wst_timing: rd/wr/rv=%b/%b/%b want 0000/0001/0010", o_rd, o_wr, o_rv);
        end
        n_cmp++;
        if (o_addr !== 32'd4 || o_wdata !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL wst_data: addr=%h wd=%h want 4 deadbeef", o_addr, o_wdata);
        end
        issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
        observe();
        n_cmp++;
        if ({o_rd, o_wr, o_rv} !== {4'b0001, 4'b0000, 4'b0010}) begin
            n_bad++;
            $display("FAIL wld_timing: rd/wr/rv=%b/%b/%b want 0001/0000/0010", o_rd, o_wr, o_rv);
        end
        n_cmp++;
        if (o_rdata !== 32'hDEADBEEF || o_err !== 1'b0) begin
            n_bad++;
            $display("FAIL wld_data: rdata=%h err=%b want deadbeef 0", o_rdata, o_err);
        end
    endtask

    task automatic test_byte_rmw();
        mem[4] = 32'h11223344;
        issue(1'b1, SZ_BYTE, 1'b0, 32'h12, 32'h123456AA);
        observe();
        n_cmp++;
        if ({o_rd, o_wr, o_rv} !== {4'b0001, 4'b0010, 4'b0100}) begin
            n_bad++;
            $display("FAIL bst_timing: rd/wr/rv=%b/%b/%b want 0001/0010/0100", o_rd, o_wr, o_rv);
        end
        n_cmp++;
        if (o_wdata !== 32'h11AA3344 || mem[4] !== 32'h11AA3344) begin
            n_bad++;
            $display("FAIL bst_merge: wd=%h mem=%h want 11aa3344", o_wdata, mem[4]);
        end
        issue(1'b1, SZ_HALF, 1'b0, 32'h10, 32'hFFFFBEEF);
        observe();
        n_cmp++;
        if (mem[4] !== 32'h11AABEEF) begin
            n_bad++;
            $display("FAIL hst_merge_lo: mem=%h want 11aabeef", mem[4]);
        end
    endtask

    task automatic test_extension();
        logic [1:0]  sz  [8] = '{SZ_BYTE, SZ_HALF, SZ_HALF, SZ_BYTE,
                                 SZ_BYTE, SZ_BYTE, SZ_HALF, SZ_WORD};
        logic        un  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] ad  [8] = '{32'h12, 32'h12, 32'h12, 32'h10,
                                 32'h11, 32'h13, 32'h10, 32'h10};
        logic [31:0] exp [8] = '{32'hFFFFFFFF, 32'h000080FF, 32'hFFFF80FF,
                                 32'h00000001, 32'h0000007F, 32'h00000080,
                                 32'h00007F01, 32'h80FF7F01};
        mem[4] = 32'h80FF7F01;
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, sz[i], un[i], ad[i], 32'h0);
            observe();
            n_cmp++;
            if (o_rv !== 4'b0010 || o_rdata !== exp[i] || o_err !== 1'b0) begin
                n_bad++;
                $display("FAIL ext_%0d: rv=%b rdata=%h err=%b want 0010 %h 0",
                         i, o_rv, o_rdata, o_err, exp[i]);
            end
        end
    endtask

    task automatic test_errors();
        logic [1:0]  sz [4] = '{SZ_HALF, SZ_WORD, 2'b11, SZ_WORD};
        logic [31:0] ad [4] = '{32'h11, 32'h12, 32'h10, 32'h100};
        logic [31:0] snap [0:63];
        int diffs;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 64; k++) snap[k] = mem[k];
            issue(1'b1, sz[i], 1'b0, ad[i], 32'hA5A5A5A5);
            observe();
            diffs = 0;
            for (int k = 0; k < 64; k++)
                if (mem[k] !== snap[k]) diffs++;
            n_cmp++;
            if (o_rv !== 4'b0001 || o_err !== 1'b1 || o_rd !== 4'b0 ||
                o_wr !== 4'b0 || o_rdata !== 32'h0 || diffs != 0) begin
                n_bad++;
                $display("FAIL err_%0d: rv=%b err=%b rd=%b wr=%b rdata=%h diffs=%0d want 0001 1 0000 0000 0 0",
                         i, o_rv, o_err, o_rd, o_wr, o_rdata, diffs);
            end
        end
        mem[63] = 32'h0BADF00D;
        issue(1'b0, SZ_WORD, 1'b0, 32'hFC, 32'h0);
        observe();
        n_cmp++;
        if (o_rv !== 4'b0010 || o_err !== 1'b0 || o_rdata !== 32'h0BADF00D) begin
            n_bad++;
            $display("FAIL last_idx: rv=%b err=%b rdata=%h want 0010 0 0badf00d",
                     o_rv, o_err, o_rdata);
        end
    endtask

    task automatic test_reset_mid();
        int bad_evt = 0;
        mem[4] = 32'h55667788;
        issue(1'b1, SZ_HALF, 1'b0, 32'h12, 32'hBEEF);
        #2;
        n_cmp++;
        if (mem_read !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_pre: mem_read=%b want 1", mem_read);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_async: rd=%b wr=%b ready=%b want 0 0 1",
                     mem_read, mem_write, req_ready);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || mem_write !== 1'b0) bad_evt++;
        end
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || mem_write !== 1'b0 || req_ready !== 1'b1) bad_evt++;
        end
        n_cmp++;
        if (bad_evt != 0 || mem[4] !== 32'h55667788) begin
            n_bad++;
            $display("FAIL rst_quiet: events=%0d mem=%h want 0 55667788", bad_evt, mem[4]);
        end
        issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
        observe();
        n_cmp++;
        if (o_rv !== 4'b0010 || o_rdata !== 32'h55667788) begin
            n_bad++;
            $display("FAIL rst_reload: rv=%b rdata=%h want 0010 55667788", o_rv, o_rdata);
        end
    endtask

    task automatic test_back_to_back();
        int accepts = 0;
        logic [2:0] rdy;
        logic [2:0] rv;
        mem[5] = 32'h0;
        @(negedge clk);
        req_write = 1'b1; req_size = SZ_BYTE; req_unsigned = 1'b0;
        req_addr = 32'h15; req_wdata = 32'h5A; req_valid = 1'b1;
        if (req_valid && req_ready) accepts++;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            rdy[c] = req_ready;
            rv[c]  = resp_valid;
            if (req_valid && req_ready) accepts++;
        end
        n_cmp++;
        if (accepts != 1 || rdy !== 3'b000 || rv !== 3'b100) begin
            n_bad++;
            $display("FAIL hold_once: accepts=%0d ready=%b rv=%b want 1 000 100",
                     accepts, rdy, rv);
        end
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1 || mem[5] !== 32'h00005A00) begin
            n_bad++;
            $display("FAIL idle_after: ready=%b mem=%h want 1 00005a00", req_ready, mem[5]);
        end
        req_write = 1'b0; req_size = SZ_WORD; req_addr = 32'h14;
        @(posedge clk);
        #1 req_valid = 1'b0;
        observe();
        n_cmp++;
        if (o_rv !== 4'b0010 || o_rdata !== 32'h00005A00) begin
            n_bad++;
            $display("FAIL second_req: rv=%b rdata=%h want 0010 00005a00", o_rv, o_rdata);
        end
    endtask

    initial begin
        for (int k = 0; k < 64; k++) mem[k] = 32'h0;
        test_reset();
        test_word_store_load();
        test_byte_rmw();
        test_extension();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator that sits between the multicycle core datapath and the word-addressed data memory. Accepts one byte/halfword/word request from the core, converts the byte address into a word index, and drives the memory's read/write strobes. Sub-word stores are done as a read-modify-write. Returns aligned, sign- or zero-extended load data, or an error for misaligned or out-of-range accesses.

## Interface
- DEPTH, 64: number of 32-bit words in the attached memory; valid word indices are 0..DEPTH-1.
- clk  in  1  sole clock; everything samples on posedge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads only; 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  qualifies resp_valid; request was rejected.
- mem_address  out  32  word index, {2'b0, addr[31:2]}.
- mem_write_data  out  32  full word to write.
- mem_read  out  1  memory read strobe; memory read data is combinational.
- mem_write  out  1  memory write strobe; memory writes on posedge.
- mem_data  in  32  memory read data.

## Operation
- FSM states: IDLE, RD, WR, RESP.
- Accept condition: req_valid && req_ready. On accept, latch write, size, unsigned, addr and wdata. Compute err = misaligned || size==11 || addr[31:2] >= DEPTH.
- Misaligned means:
  - half: addr[0]=1
  - word: addr[1:0]≠0
- Transitions out of IDLE on accept:
  - err → RESP.
  - load → RD.
  - word store → WR.
  - byte/half store → RD.
- RD: mem_read=1. Capture mem_data into word register.
  - load → RESP.
  - sub-word store → WR.
- WR: mem_write=1; mem_write_data = merged word.
- RESP: resp_valid=1 → IDLE.
- Byte store merge: lane addr[1:0] (bits 8*off+7:8*off) ← wdata[7:0]. Other lanes come from the captured word.
- Half store merge: addr[1] selects bits [31:16] vs [15:0], ← wdata[15:0].
- Word store: mem_write_data = wdata.
- Load extract: the selected lane is shifted to bit 0, then extended to 32 bits per req_unsigned. Word loads are passed through.
- mem_address holds the latched word index from accept until the next accept.
- mem_read and mem_write are never both high.
- An error request produces no memory strobe.

## Timing
- Cycle 0 is the accept edge.
- Latencies (resp_valid cycle):
  - error: 1.
  - load: 2.
  - word store: 2.
  - sub-word store: 3.
- Strobe timing:
  - load: mem_read in cycle 1.
  - word store: mem_write in cycle 1.
  - sub-word store: mem_read in cycle 1, mem_write in cycle 2.
- A new request can be accepted in the cycle after RESP (IDLE). There is no back-to-back overlap.
- req_valid while not ready is ignored. The core must hold the request until accepted.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_address=0, mem_write_data=0, mem_read=0, mem_write=0.
- Reset asserted mid-operation:
  - FSM goes to IDLE immediately and strobes drop asynchronously.
  - No response is issued.
  - A sub-word store interrupted in RD leaves memory untouched.
- resp_rdata and resp_err are valid only while resp_valid=1. They are zero otherwise.

## Structure
- Package mem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - the state enum {IDLE, RD, WR, RESP}.
  - the DEPTH default.
- Sub-module mem_lane_unit is combinational.
  - Inputs: addr[1:0], size, unsigned, old word, wdata.
  - Outputs: merged store word and extended load word.
- Top-level holds the FSM, request latch and output registers.

## Test plan
- Word store then load: store addr 0x10 wdata 0xDEADBEEF → mem_write in cycle 1 at mem_address 4, resp_valid in cycle 2. Load addr 0x10 → resp_rdata 0xDEADBEEF in cycle 2, resp_err=0.
- Byte store RMW: word 4 holds 0x11223344. Store byte addr 0x12 wdata 0xAA → mem_read cycle 1, mem_write cycle 2 with 0x11AA3344, resp cycle 3.
- Sign/zero extension: word 4 holds 0x80FF7F01.
  - byte load addr 0x12 signed → 0xFFFFFFFF.
  - half load addr 0x12 unsigned → 0x000080FF.
  - half load addr 0x12 signed → 0xFFFF80FF.
- Errors, each giving resp_valid with resp_err=1 in cycle 1, no strobes, and memory unchanged:
  - half at 0x11.
  - word at 0x12.
  - size 11.
  - word at 0x100 (index 64).
- Reset during a half store: assert reset while in RD → strobes low immediately, no resp_valid, word unchanged. After release req_ready=1 and a fresh load returns the old data.
- Handshake: hold req_valid across a 3-cycle store → only one accept. req_ready=0 during RD/WR/RESP. A second request is accepted in the IDLE cycle after resp_valid.
